// File: rtl/pipe_skid_reg.sv
// Elastic valid/ready pipeline stage with a skid slot so in_ready comes straight from a flop.
// Adds a synchronous flush and a saturating downstream-stall counter.
module pipe_skid_reg #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [1:0]           occupancy,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     main_q, main_d;
    logic [WIDTH-1:0]     skid_q, skid_d;
    logic                 in_ready_q, in_ready_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic                 in_fire, out_fire;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign in_ready  = in_ready_q;
    assign stall_cnt = stall_cnt_q;
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            BUSY:    occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d  = in_data;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    skid_d  = in_data;
                    state_d = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Squash only retires state; data regs keep stale contents behind out_valid=0.
        if (flush) state_d = EMPTY;
        in_ready_d = (state_d != FULL);

        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_WIDTH{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg; a second instance with a 4-bit counter shares the stimulus.
module tb_pipe_skid_reg;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;

    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_data;
    logic [1:0]  s_occupancy;
    logic [3:0]  s_stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_skid_reg #(.WIDTH(32), .CNT_WIDTH(4)) dut_sat (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        tick(); tick();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got %h exp 0", out_data); end
        n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
        n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall got %0d exp 0", stall_cnt); end
        reset = 1'b0;
    endtask

    task automatic test_streaming();
        logic [31:0] words [3];
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = words[i];
            tick();
            n_checks++; if (out_valid !== 1'b1 || out_data !== words[i]) begin
                n_fail++; $display("FAIL stream_word%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, words[i]);
            end
            n_checks++; if (in_ready !== 1'b1 || occupancy !== 2'd1) begin
                n_fail++; $display("FAIL stream_ready_occ%0d got rdy=%b occ=%0d exp rdy=1 occ=1", i, in_ready, occupancy);
            end
        end
        in_valid = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            n_fail++; $display("FAIL stream_drained got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy);
        end
        n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL stream_stall got %0d exp 0", stall_cnt); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA0;
        tick();
        n_checks++; if (occupancy !== 2'd1 || out_data !== 32'hA0 || stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL bp_first got occ=%0d d=%h st=%0d exp occ=1 d=a0 st=0", occupancy, out_data, stall_cnt);
        end
        in_data = 32'hB0;
        tick();
        n_checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || stall_cnt !== 16'd1) begin
            n_fail++; $display("FAIL bp_full got occ=%0d rdy=%b st=%0d exp occ=2 rdy=0 st=1", occupancy, in_ready, stall_cnt);
        end
        in_data = 32'hC0;
        tick();
        n_checks++; if (occupancy !== 2'd2 || out_data !== 32'hA0 || out_valid !== 1'b1 || stall_cnt !== 16'd2) begin
            n_fail++; $display("FAIL bp_hold1 got occ=%0d d=%h v=%b st=%0d exp occ=2 d=a0 v=1 st=2", occupancy, out_data, out_valid, stall_cnt);
        end
        tick();
        n_checks++; if (occupancy !== 2'd2 || out_data !== 32'hA0 || in_ready !== 1'b0 || stall_cnt !== 16'd3) begin
            n_fail++; $display("FAIL bp_hold2 got occ=%0d d=%h rdy=%b st=%0d exp occ=2 d=a0 rdy=0 st=3", occupancy, out_data, in_ready, stall_cnt);
        end
    endtask

    task automatic test_drain();
        out_ready = 1'b1;
        // 0xA0 is consumed on this edge; 0xC0 is still offered upstream
        tick();
        n_checks++; if (out_data !== 32'hB0 || occupancy !== 2'd1 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL drain_b0 got d=%h occ=%0d rdy=%b exp d=b0 occ=1 rdy=1", out_data, occupancy, in_ready);
        end
        tick();
        n_checks++; if (out_data !== 32'hC0 || out_valid !== 1'b1 || occupancy !== 2'd1) begin
            n_fail++; $display("FAIL drain_c0 got d=%h v=%b occ=%0d exp d=c0 v=1 occ=1", out_data, out_valid, occupancy);
        end
        in_valid = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || stall_cnt !== 16'd3) begin
            n_fail++; $display("FAIL drain_empty got v=%b occ=%0d st=%0d exp v=0 occ=0 st=3", out_valid, occupancy, stall_cnt);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h01;
        tick();
        in_data = 32'h02;
        tick();
        n_checks++; if (occupancy !== 2'd2 || stall_cnt !== 16'd4) begin
            n_fail++; $display("FAIL flush_pre got occ=%0d st=%0d exp occ=2 st=4", occupancy, stall_cnt);
        end
        flush = 1'b1; in_data = 32'hDD;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_empty got v=%b occ=%0d rdy=%b exp v=0 occ=0 rdy=1", out_valid, occupancy, in_ready);
        end
        n_checks++; if (stall_cnt !== 16'd5) begin n_fail++; $display("FAIL flush_stall got %0d exp 5", stall_cnt); end
        tick();
        n_checks++; if (out_valid !== 1'b0 || stall_cnt !== 16'd5) begin
            n_fail++; $display("FAIL flush_after got v=%b st=%0d exp v=0 st=5", out_valid, stall_cnt);
        end
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h33;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_data !== 32'h33 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL flush_next_word got v=%b d=%h exp v=1 d=33", out_valid, out_data);
        end
    endtask

    task automatic test_saturation();
        // 0x33 sits in main; both instances start this window at 5 stalls
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        n_checks++; if (s_stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_cnt4 got %0d exp 15", s_stall_cnt); end
        n_checks++; if (stall_cnt !== 16'd25) begin n_fail++; $display("FAIL sat_cnt16 got %0d exp 25", stall_cnt); end
        n_checks++; if (out_data !== 32'h33 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL sat_stable got v=%b d=%h exp v=1 d=33", out_valid, out_data);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (s_stall_cnt !== 4'd0 || stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL sat_reset got %0d/%0d exp 0/0", s_stall_cnt, stall_cnt);
        end
    endtask

    task automatic test_reset_midop();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h44;
        tick();
        in_data = 32'h55;
        tick();
        n_checks++; if (occupancy !== 2'd2 || stall_cnt !== 16'd1) begin
            n_fail++; $display("FAIL midrst_pre got occ=%0d st=%0d exp occ=2 st=1", occupancy, stall_cnt);
        end
        reset = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
        tick();
        reset = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 || occupancy !== 2'd0) begin
            n_fail++; $display("FAIL midrst_state got v=%b rdy=%b d=%h occ=%0d exp v=0 rdy=1 d=0 occ=0", out_valid, in_ready, out_data, occupancy);
        end
        tick();
        n_checks++; if (out_valid !== 1'b0 || stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL midrst_after got v=%b st=%0d exp v=0 st=0", out_valid, stall_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_drain();
        test_flush();
        test_saturation();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
